key_conditioner: RTL
====================

KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable samples required to accept a press or release; legal range 2..65535.
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 key_raw  input  4  raw push-button levels, active-low (0 = pressed), asynchronous to clock.
REQ-005 key  output  4  registered one-hot single-cycle press pulse; drives the digitalLock key input directly.
REQ-006 key_held  output  1  registered; high while an accepted key is held or its release is being debounced.

Function
REQ-007 The block SHALL form pressed[3:0] = ~key_in, where key_in is key_raw or its synchronised copy (see REQ-020).
REQ-008 The block SHALL implement a four-state FSM: IDLE, DB_PRESS, HELD, DB_RELEASE, plus a counter sized for DEBOUNCE_CYCLES and a 4-bit candidate register.
REQ-009 IDLE: if pressed has exactly one bit set, the FSM SHALL load candidate = pressed and count = 1, then enter DB_PRESS; zero or multiple bits set SHALL leave the FSM in IDLE.
REQ-010 DB_PRESS: if pressed != candidate, the FSM SHALL clear count and return to IDLE with no pulse.
REQ-011 DB_PRESS: if pressed == candidate, count SHALL increment; on the edge where count reaches DEBOUNCE_CYCLES, the block SHALL register key = candidate and enter HELD.
REQ-012 Press latency: key SHALL be high in the cycle following the DEBOUNCE_CYCLES-th consecutive sampling edge with pressed == candidate, counting the IDLE acceptance edge as the first.
REQ-013 key SHALL be high for exactly one cycle per accepted press, and SHALL be 4'b0000 in all other cycles.
REQ-014 HELD: additional or changed presses SHALL be ignored; when pressed == 0, the FSM SHALL load count = 1 and enter DB_RELEASE.
REQ-015 DB_RELEASE: any pressed bit set SHALL return the FSM to HELD with count cleared; DEBOUNCE_CYCLES consecutive samples of pressed == 0 (entry edge included) SHALL return it to IDLE.
REQ-016 key_held SHALL be 1 in HELD and DB_RELEASE, and 0 in IDLE and DB_PRESS (registered alongside state).
REQ-017 A simultaneous multi-key press SHALL never produce a pulse unless it resolves to a single key that is stable for DEBOUNCE_CYCLES samples.
REQ-018 The counter SHALL saturate and never wrap; the FSM SHALL never hold an undefined encoding, and any illegal state SHALL go to IDLE on the next edge.

Reset
REQ-019 While reset is high at a clock edge, the block SHALL set state = IDLE, count = 0, candidate = 0, key = 4'b0000, key_held = 0, and synchroniser flops = 4'b1111. Reset asserted mid-debounce or mid-hold SHALL discard the pending press with no pulse. After reset, a key already held SHALL be treated as a fresh press.

Configuration
REQ-020 Macro KEY_SYNC_EN: when defined, key_raw SHALL pass through a two-flop synchroniser before pressed is formed, adding exactly 2 cycles to every latency. When undefined, key_raw SHALL feed pressed combinationally, with no added latency; port list and FSM behaviour are identical in both cases.

Verification (DEBOUNCE_CYCLES = 4, KEY_SYNC_EN undefined unless stated)
REQ-021 key_raw = 4'b1110 held from edge E0 -> key = 4'b0001 for one cycle after E3; key_held = 1 from E3 onward.
REQ-022 key_raw = 4'b1101 for 2 edges, 4'b1111 for 1 edge, 4'b1101 for 4 edges -> exactly one key = 4'b0010 pulse, occurring after the 4th edge of the final run.
REQ-023 key_raw = 4'b1100 for 10 edges -> key remains 4'b0000 and key_held remains 0 throughout.
REQ-024 Hold 4'b0111 until the pulse, bounce release 1111/0111/1111 x3, then 4'b1011 -> first pulse 4'b1000; IDLE is reached only after 4 clean release edges; second pulse 4'b0100 arrives 4 edges after IDLE accepts it.
REQ-025 Assert reset at count = 2 in DB_PRESS with key_raw = 4'b1110 held -> no pulse; after reset deasserts, a pulse 4'b0001 follows 4 edges later.
REQ-026 With KEY_SYNC_EN defined, repeat REQ-021 -> the pulse occurs after E5, with identical one-cycle width.

Source files
------------

// File: rtl/key_conditioner.sv
// Debounced push-button conditioner: one-hot single-cycle press pulse plus held flag.
// Optional two-flop input synchroniser enabled by defining KEY_SYNC_EN.
`timescale 1ns/1ps
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_raw,
  output logic [3:0] key,
  output logic       key_held
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    key_q, key_d;
  logic          held_q, held_d;

  logic [3:0]    key_in;
  logic [3:0]    pressed;
  logic          one_hot;
  logic [CW-1:0] cnt_inc;

`ifdef KEY_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign key_in = sync2_q;
`else
  assign key_in = key_raw;
`endif

  assign pressed = ~key_in;
  assign one_hot = (pressed != 4'd0) && ((pressed & (pressed - 4'd1)) == 4'd0);
  assign cnt_inc = (count_q == '1) ? count_q : count_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cand_d  = cand_q;
    key_d   = '0;
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (one_hot) begin
          cand_d  = pressed;
          count_d = CNT_ONE;
          state_d = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (pressed != cand_q) begin
          count_d = '0;
          state_d = IDLE;
        end else if (count_q >= CNT_LAST) begin
          count_d = cnt_inc;
          key_d   = cand_q;
          state_d = HELD;
        end else begin
          count_d = cnt_inc;
        end
      end
      HELD: begin
        // Any further key activity is ignored until everything is released.
        if (pressed == 4'd0) begin
          count_d = CNT_ONE;
          state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (pressed != 4'd0) begin
          count_d = '0;
          state_d = HELD;
        end else if (count_q >= CNT_LAST) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = cnt_inc;
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
    held_d = (state_d == HELD) || (state_d == DB_RELEASE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      held_q  <= held_d;
    end
  end

  assign key      = key_q;
  assign key_held = held_q;

endmodule
